mem_access_stage: RTL and testbench

Memory-access stage of the sequential RV64 core, sitting between execute and writeback. It accepts one execute result per transaction: ALU result, store data, destination register and memory/writeback controls. It performs the `ld`/`sd` over a request/grant/response data-memory port and delivers one writeback record per accepted instruction. Non-memory instructions pass through with fixed one-cycle latency.

---
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Memory-access stage of the sequential RV64 core, between execute and
// writeback. Accepts one execute record per transaction, performs the ld/sd
// over a request/grant/response data-memory port, and emits one writeback
// record per accepted instruction. Non-memory records pass through in one cycle.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : execute record handshake (ready only when idle)
//   ALUResult, WriteData, RdOut, MemReadOut, MemWriteOut, MemtoRegOut,
//   RegWriteOut         : execute record fields
//   mem_req/we/addr/wdata : data-memory request (registered)
//   mem_gnt             : memory accepts the request this cycle
//   mem_rvalid/rdata    : load response
//   wb_valid/rd/data/regwrite/err : one-cycle writeback record (registered)
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ALUResult,
  input  logic [63:0] WriteData,
  input  logic [4:0]  RdOut,
  input  logic        MemReadOut,
  input  logic        MemWriteOut,
  input  logic        MemtoRegOut,
  input  logic        RegWriteOut,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_regwrite,
  output logic        wb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Last counter value still allowed in REQ/WAIT before the transaction is aborted.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  cnt;
  logic [7:0]  cnt_next;
  logic        done_err;
  logic        load_hit;
  logic        accept;

  logic [63:0] lat_alu;
  logic [63:0] lat_wdata;
  logic [4:0]  lat_rd;
  logic        lat_write;
  logic        lat_memtoreg;
  logic        lat_regwrite;

  // Record fields as seen this cycle: straight from the inputs while idle
  // (the accept edge), from the latched copy afterwards.
  logic [63:0] sel_alu;
  logic [63:0] sel_wdata;
  logic [4:0]  sel_rd;
  logic        sel_write;
  logic        sel_regwrite;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // Select current record fields for the registered output computation.
  always_comb begin
    if (state == IDLE) begin
      sel_alu      = ALUResult;
      sel_wdata    = WriteData;
      sel_rd       = RdOut;
      sel_write    = MemWriteOut;
      sel_regwrite = RegWriteOut;
    end else begin
      sel_alu      = lat_alu;
      sel_wdata    = lat_wdata;
      sel_rd       = lat_rd;
      sel_write    = lat_write;
      sel_regwrite = lat_regwrite;
    end
  end

  // Next-state, timeout counter and completion status.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    done_err   = 1'b0;
    load_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          cnt_next = 8'd0;
          if ((MemReadOut & MemWriteOut) |
              ((MemReadOut | MemWriteOut) & (ALUResult[2:0] != 3'b000))) begin
            next_state = DONE;
            done_err   = 1'b1;
          end else if (MemReadOut | MemWriteOut) begin
            next_state = REQ;
          end else begin
            next_state = DONE;
          end
        end else begin
          next_state = IDLE;
        end
      end
      REQ: begin
        // A grant wins over a timeout in the same cycle; rvalid is ignored here.
        if (mem_gnt) begin
          next_state = lat_write ? DONE : WAIT;
          cnt_next   = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end else if (cnt >= TIMEOUT_LAST) begin
          next_state = DONE;
          done_err   = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          next_state = DONE;
          load_hit   = 1'b1;
        end else if (cnt >= TIMEOUT_LAST) begin
          next_state = DONE;
          done_err   = 1'b1;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register, record latch and timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      lat_alu      <= 64'd0;
      lat_wdata    <= 64'd0;
      lat_rd       <= 5'd0;
      lat_write    <= 1'b0;
      lat_memtoreg <= 1'b0;
      lat_regwrite <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (accept) begin
        lat_alu      <= ALUResult;
        lat_wdata    <= WriteData;
        lat_rd       <= RdOut;
        lat_write    <= MemWriteOut;
        lat_memtoreg <= MemtoRegOut;
        lat_regwrite <= RegWriteOut;
      end
    end
  end

  // Registered memory-port and writeback outputs, computed from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      wb_valid    <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 64'd0;
      wb_regwrite <= 1'b0;
      wb_err      <= 1'b0;
    end else begin
      if (next_state == REQ) begin
        mem_req   <= 1'b1;
        mem_we    <= sel_write;
        mem_addr  <= sel_alu;
        mem_wdata <= sel_wdata;
      end else begin
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
        mem_addr  <= 64'd0;
        mem_wdata <= 64'd0;
      end
      if (next_state == DONE) begin
        wb_valid    <= 1'b1;
        wb_rd       <= sel_rd;
        wb_data     <= (load_hit & lat_memtoreg) ? mem_rdata : sel_alu;
        wb_regwrite <= sel_regwrite & ~done_err & (sel_rd != 5'd0);
        wb_err      <= done_err;
      end else begin
        wb_valid    <= 1'b0;
        wb_rd       <= 5'd0;
        wb_data     <= 64'd0;
        wb_regwrite <= 1'b0;
        wb_err      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ALUResult;
  logic [63:0] WriteData;
  logic [4:0]  RdOut;
  logic        MemReadOut;
  logic        MemWriteOut;
  logic        MemtoRegOut;
  logic        RegWriteOut;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        wb_regwrite;
  logic        wb_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUResult(ALUResult), .WriteData(WriteData), .RdOut(RdOut),
    .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .MemtoRegOut(MemtoRegOut), .RegWriteOut(RegWriteOut),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_regwrite(wb_regwrite), .wb_err(wb_err)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_rvalid();
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata  = {$urandom, $urandom};
  endtask

  // One instruction from accept to the idle cycle after writeback.
  // dg: cycles in REQ without grant before the grant; dr: WAIT cycles before rvalid.
  task automatic run_txn(input logic rd_c, input logic wr_c, input logic mtr, input logic rw,
                         input logic [63:0] alu, input logic [63:0] wd, input logic [4:0] rdst,
                         input int dg, input int dr, input logic [63:0] rdata);
    int          lat;
    int          req_end;
    int          rv_cyc;
    logic        bad;
    logic        is_mem;
    logic        exp_err;
    logic        ok_load;
    logic        in_wait;
    logic [2:0]  low;
    logic [63:0] exp_data;

    // Reference: latency and result from cycle counts in REQ+WAIT.
    low     = alu[2:0];
    is_mem  = rd_c | wr_c;
    bad     = (rd_c & wr_c) | (is_mem & (low != 3'd0));
    ok_load = 1'b0;
    rv_cyc  = -1;
    req_end = 0;
    if (bad || !is_mem) begin
      lat     = 1;
      exp_err = bad;
    end else if (dg >= T) begin
      req_end = T;
      lat     = T + 1;
      exp_err = 1'b1;
    end else if (wr_c) begin
      req_end = dg + 1;
      lat     = dg + 2;
      exp_err = 1'b0;
    end else begin
      req_end = dg + 1;
      rv_cyc  = dg + 2 + dr;
      if (dg + dr + 2 <= T) begin
        ok_load = 1'b1;
        lat     = dg + dr + 3;
        exp_err = 1'b0;
      end else begin
        lat     = T + 1;
        exp_err = 1'b1;
      end
    end
    exp_data = (ok_load && mtr) ? rdata : alu;

    check_eq("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    in_valid    = 1'b1;
    ALUResult   = alu;
    WriteData   = wd;
    RdOut       = rdst;
    MemReadOut  = rd_c;
    MemWriteOut = wr_c;
    MemtoRegOut = mtr;
    RegWriteOut = rw;
    mem_gnt     = 1'b0;
    junk_rvalid();
    step();
    // Scramble the execute inputs to show the stage uses its latched copy.
    in_valid    = 1'b0;
    ALUResult   = {$urandom, $urandom};
    WriteData   = {$urandom, $urandom};
    RdOut       = 5'($urandom);
    MemReadOut  = 1'($urandom);
    MemWriteOut = 1'($urandom);
    MemtoRegOut = 1'($urandom);
    RegWriteOut = 1'($urandom);

    for (int k = 1; k <= lat + 1; k++) begin
      check_eq("mem_req", {63'd0, mem_req}, {63'd0, (k <= req_end)});
      if (k <= req_end) begin
        check_eq("mem_we", {63'd0, mem_we}, {63'd0, wr_c});
        check_eq("mem_addr", mem_addr, alu);
        check_eq("mem_wdata", mem_wdata, wd);
      end
      check_eq("wb_valid", {63'd0, wb_valid}, {63'd0, (k == lat)});
      check_eq("in_ready", {63'd0, in_ready}, {63'd0, (k == lat + 1)});
      if (k == lat) begin
        check_eq("wb_rd", {59'd0, wb_rd}, {59'd0, rdst});
        check_eq("wb_data", wb_data, exp_data);
        check_eq("wb_err", {63'd0, wb_err}, {63'd0, exp_err});
        check_eq("wb_regwrite", {63'd0, wb_regwrite},
                 {63'd0, (rw & ~exp_err & (rdst != 5'd0))});
      end else begin
        check_eq("wb_rd_idle", {59'd0, wb_rd}, 64'd0);
        check_eq("wb_data_idle", wb_data, 64'd0);
      end
      if (k == lat + 1) break;
      mem_gnt = (k == dg + 1) && (k <= req_end);
      in_wait = is_mem && !bad && !wr_c && (dg < T) && (k >= dg + 2) && (k < lat);
      if (ok_load && k == rv_cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
      end else if (in_wait || (k == dg + 1)) begin
        mem_rvalid = 1'b0;
        mem_rdata  = {$urandom, $urandom};
      end else begin
        junk_rvalid();
      end
      step();
    end
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    int          kind;
    int          dg;
    rst = 1'b1;
    in_valid = 1'b0; ALUResult = 64'd0; WriteData = 64'd0; RdOut = 5'd0;
    MemReadOut = 1'b0; MemWriteOut = 1'b0; MemtoRegOut = 1'b0; RegWriteOut = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check_eq("rst_mem_addr", mem_addr, 64'd0);
    check_eq("rst_mem_wdata", mem_wdata, 64'd0);
    check_eq("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("rst_wb_data", wb_data, 64'd0);
    check_eq("rst_wb_flags", {59'd0, wb_rd, mem_we, wb_regwrite, wb_err}, 64'd0);

    // Directed cases.
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 64'h1234, 64'd0, 5'd5, 0, 0, 64'd0);
    run_txn(1'b0, 1'b1, 1'b0, 1'b0, 64'h80, 64'hDEADBEEF, 5'd0, 3, 0, 64'd0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 64'h100, 64'd0, 5'd7, 0, 2, 64'hCAFEF00D);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 64'h104, 64'd0, 5'd7, 0, 0, 64'd0);
    run_txn(1'b1, 1'b1, 1'b1, 1'b1, 64'h200, 64'h55, 5'd9, 0, 0, 64'd0);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 64'h300, 64'd0, 5'd0, 1, 0, 64'h77);
    run_txn(1'b1, 1'b0, 1'b1, 1'b1, 64'h400, 64'd0, 5'd3, 0, 20, 64'h99);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, 64'h408, 64'h66, 5'd4, 9, 0, 64'd0);

    // Reset while waiting for load data, then a stale rvalid.
    in_valid = 1'b1; ALUResult = 64'h500; WriteData = 64'd0; RdOut = 5'd6;
    MemReadOut = 1'b1; MemWriteOut = 1'b0; MemtoRegOut = 1'b1; RegWriteOut = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("rst_mid_req", {63'd0, mem_req}, 64'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check_eq("rst_mid_wait_req", {63'd0, mem_req}, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_mid_outs", {58'd0, mem_req, wb_valid, wb_regwrite, wb_err, mem_we, 1'b0}, 64'd0);
    check_eq("rst_mid_wb_data", wb_data, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'hBAD;
    step();
    mem_rvalid = 1'b0;
    check_eq("stale_rvalid_wb_valid", {63'd0, wb_valid}, 64'd0);
    check_eq("stale_rvalid_in_ready", {63'd0, in_ready}, 64'd1);
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, 64'hABCD, 64'd0, 5'd12, 0, 0, 64'd0);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      a    = {$urandom, $urandom};
      d    = {$urandom, $urandom};
      dg   = $urandom_range(0, 5);
      if (kind == 3) a[2:0] = 3'($urandom_range(1, 7));
      else if (kind != 0) a[2:0] = 3'd0;
      if (kind == 1 && dg == T - 1) dg = T - 2;
      run_txn((kind == 1) || (kind == 4) || (kind == 3 && d[0]),
              (kind == 2) || (kind == 4) || (kind == 3 && !d[0]),
              1'($urandom), 1'($urandom), a, d, 5'($urandom),
              dg, $urandom_range(0, 3), {$urandom, $urandom});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
